ps_fifo_wavepool_decode: RTL and testbench

//  Parametrised elastic pipeline stage between the wavepool and decode. It

---
 rtl/ps_fifo_wavepool_decode.sv | 139 +++++++++++++
 tb/tb_ps_fifo_wavepool_decode.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps_fifo_wavepool_decode.sv
// Elastic wavepool->decode stage: DEPTH-entry circular FIFO with valid/ready
// handshake, per-wavefront squash and global flush. Squashed entries keep
// their slot until the dead head is auto-dropped, one per cycle.
module ps_fifo_wavepool_decode #(
    parameter int unsigned  PC_W    = 32,
    parameter int unsigned  INSTR_W = 32,
    parameter int unsigned  WFID_W  = 6,
    parameter int unsigned  VGPR_W  = 10,
    parameter int unsigned  SGPR_W  = 9,
    parameter int unsigned  LDS_W   = 16,
    parameter int unsigned  DEPTH   = 2,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [WFID_W-1:0]  in_wfid,
    input  logic [VGPR_W-1:0]  in_vgpr_base,
    input  logic [SGPR_W-1:0]  in_sgpr_base,
    input  logic [LDS_W-1:0]   in_lds_base,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [WFID_W-1:0]  out_wfid,
    output logic [VGPR_W-1:0]  out_vgpr_base,
    output logic [SGPR_W-1:0]  out_sgpr_base,
    output logic [LDS_W-1:0]   out_lds_base,
    input  logic               flush_valid,
    input  logic [WFID_W-1:0]  flush_wfid,
    input  logic               flush_all,
    output logic [CNT_W-1:0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PC_W-1:0]    pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [WFID_W-1:0]  wfid_q  [DEPTH];
    logic [VGPR_W-1:0]  vgpr_q  [DEPTH];
    logic [SGPR_W-1:0]  sgpr_q  [DEPTH];
    logic [LDS_W-1:0]   lds_q   [DEPTH];

    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic not_empty, head_live, head_squash, push, pop;

    // Handshake and head qualification; in_ready looks only at registered count
    always_comb begin
        not_empty   = (count_q != CNT_W'(0));
        head_live   = live_q[rd_ptr_q];
        head_squash = flush_all | (flush_valid & (wfid_q[rd_ptr_q] == flush_wfid));
        in_ready    = (count_q != CNT_W'(DEPTH));
        out_valid   = not_empty & head_live & ~head_squash;
        push        = in_valid & in_ready;
        pop         = (out_valid & out_ready) | (not_empty & ~head_live);
    end

    assign out_pc        = pc_q[rd_ptr_q];
    assign out_instr     = instr_q[rd_ptr_q];
    assign out_wfid      = wfid_q[rd_ptr_q];
    assign out_vgpr_base = vgpr_q[rd_ptr_q];
    assign out_sgpr_base = sgpr_q[rd_ptr_q];
    assign out_lds_base  = lds_q[rd_ptr_q];
    assign occupancy     = count_q;

    // Next-state for pointers, count and live bits (flush, pop, then push write)
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        live_d   = live_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (flush_all || (flush_valid && (wfid_q[i] == flush_wfid))) begin
                live_d[i] = 1'b0;
            end
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            live_d[wr_ptr_q] = ~flush_all & ~(flush_valid && (in_wfid == flush_wfid));
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    // Entry payload storage, written at wr_ptr on push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                wfid_q[i]  <= '0;
                vgpr_q[i]  <= '0;
                sgpr_q[i]  <= '0;
                lds_q[i]   <= '0;
            end
        end else if (push) begin
            pc_q[wr_ptr_q]    <= in_pc;
            instr_q[wr_ptr_q] <= in_instr;
            wfid_q[wr_ptr_q]  <= in_wfid;
            vgpr_q[wr_ptr_q]  <= in_vgpr_base;
            sgpr_q[wr_ptr_q]  <= in_sgpr_base;
            lds_q[wr_ptr_q]   <= in_lds_base;
        end
    end

endmodule

// File: tb/tb_ps_fifo_wavepool_decode.sv
// Directed bench for ps_fifo_wavepool_decode: a DEPTH=2 and a DEPTH=4 copy
// share one stimulus stream; each test checks the instance it targets.
module tb_ps_fifo_wavepool_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, flush_valid, flush_all;
    logic [31:0] in_pc, in_instr;
    logic [5:0]  in_wfid, flush_wfid;
    logic [9:0]  in_vgpr;
    logic [8:0]  in_sgpr;
    logic [15:0] in_lds;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_pc, a_instr;
    logic [5:0]  a_wfid;
    logic [9:0]  a_vgpr;
    logic [8:0]  a_sgpr;
    logic [15:0] a_lds;
    logic [1:0]  a_occ;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_pc, b_instr;
    logic [5:0]  b_wfid;
    logic [9:0]  b_vgpr;
    logic [8:0]  b_sgpr;
    logic [15:0] b_lds;
    logic [2:0]  b_occ;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ps_fifo_wavepool_decode #(.DEPTH(2)) u_a (
        .clk(clk), .rst(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_wfid(in_wfid),
        .in_vgpr_base(in_vgpr), .in_sgpr_base(in_sgpr), .in_lds_base(in_lds),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_instr(a_instr), .out_wfid(a_wfid),
        .out_vgpr_base(a_vgpr), .out_sgpr_base(a_sgpr), .out_lds_base(a_lds),
        .flush_valid(flush_valid), .flush_wfid(flush_wfid), .flush_all(flush_all),
        .occupancy(a_occ)
    );

    ps_fifo_wavepool_decode #(.DEPTH(4)) u_b (
        .clk(clk), .rst(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_wfid(in_wfid),
        .in_vgpr_base(in_vgpr), .in_sgpr_base(in_sgpr), .in_lds_base(in_lds),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_instr(b_instr), .out_wfid(b_wfid),
        .out_vgpr_base(b_vgpr), .out_sgpr_base(b_sgpr), .out_lds_base(b_lds),
        .flush_valid(flush_valid), .flush_wfid(flush_wfid), .flush_all(flush_all),
        .occupancy(b_occ)
    );

    // Count one comparison and report it if it does not match
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [5:0] wf);
        in_valid = v;
        in_pc    = pc;
        in_wfid  = wf;
        in_instr = ~pc;
        in_vgpr  = 10'(pc + 32'd1);
        in_sgpr  = 9'(pc + 32'd2);
        in_lds   = 16'(pc + 32'd3);
    endtask

    logic [31:0] q[$];
    logic        mv, mr, do_push, do_pop;
    logic [31:0] rpc;

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0; flush_valid = 1'b0; flush_all = 1'b0; flush_wfid = '0;
        drive(1'b0, 32'h0, 6'd0);
        #2;
        // T1: reset state, then asynchronous reset with two entries held
        chk("rst_occ",   64'(a_occ), 64'd0);
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_ready", 64'(a_in_ready), 64'd1);
        chk("rst_pc",    64'(a_pc), 64'h0);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 32'hA0, 6'd1); tick();
        drive(1'b1, 32'hA4, 6'd2); tick();
        drive(1'b0, 32'h0, 6'd0);
        chk("t1_occ2", 64'(a_occ), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_occ",   64'(a_occ), 64'd0);
        chk("t1_async_valid", 64'(a_out_valid), 64'd0);
        chk("t1_async_ready", 64'(a_in_ready), 64'd1);
        chk("t1_async_pc",    64'(a_pc), 64'h0);
        rst_n = 1'b1;
        tick();

        // T2: one-cycle latency through an empty stage, all fields pass through
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 6'd3);
        #1 chk("t2_pre_valid", 64'(a_out_valid), 64'd0);
        tick();
        drive(1'b0, 32'h0, 6'd0);
        chk("t2_valid", 64'(a_out_valid), 64'd1);
        chk("t2_pc",    64'(a_pc), 64'h100);
        chk("t2_wfid",  64'(a_wfid), 64'd3);
        chk("t2_instr", 64'(a_instr), 64'hFFFF_FEFF);
        chk("t2_vgpr",  64'(a_vgpr), 64'h101);
        chk("t2_sgpr",  64'(a_sgpr), 64'h102);
        chk("t2_lds",   64'(a_lds), 64'h103);
        tick();
        chk("t2_popped_occ",   64'(a_occ), 64'd0);
        chk("t2_popped_valid", 64'(a_out_valid), 64'd0);

        // T3: backpressure fills DEPTH=2, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 6'd4); tick();
        drive(1'b1, 32'h14, 6'd4); tick();
        drive(1'b0, 32'h0, 6'd0);
        chk("t3_full_ready", 64'(a_in_ready), 64'd0);
        chk("t3_full_occ",   64'(a_occ), 64'd2);
        out_ready = 1'b1;
        #1;
        chk("t3_first_valid", 64'(a_out_valid), 64'd1);
        chk("t3_first_pc",    64'(a_pc), 64'h10);
        tick();
        chk("t3_second_pc",  64'(a_pc), 64'h14);
        chk("t3_second_occ", 64'(a_occ), 64'd1);
        chk("t3_ready_back", 64'(a_in_ready), 64'd1);
        tick();
        chk("t3_empty_occ", 64'(a_occ), 64'd0);

        // T4: squash wfid 5 out of {5,7,5} on the DEPTH=4 copy
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 6'd5); tick();
        drive(1'b1, 32'h34, 6'd7); tick();
        drive(1'b1, 32'h38, 6'd5); tick();
        drive(1'b0, 32'h0, 6'd0);
        chk("t4_occ3", 64'(b_occ), 64'd3);
        flush_valid = 1'b1; flush_wfid = 6'd5;
        #1 chk("t4_head_gated", 64'(b_out_valid), 64'd0);
        tick();
        flush_valid = 1'b0;
        chk("t4_after_flush_occ",   64'(b_occ), 64'd3);
        chk("t4_after_flush_valid", 64'(b_out_valid), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("t4_drop1_occ", 64'(b_occ), 64'd2);
        chk("t4_w7_valid",  64'(b_out_valid), 64'd1);
        chk("t4_w7_pc",     64'(b_pc), 64'h34);
        chk("t4_w7_wfid",   64'(b_wfid), 64'd7);
        tick();
        chk("t4_pop_occ",   64'(b_occ), 64'd1);
        chk("t4_dead_tail", 64'(b_out_valid), 64'd0);
        tick();
        chk("t4_drained",   64'(b_occ), 64'd0);
        tick();

        // T5: same-cycle push and squash, by wfid and by flush_all
        drive(1'b1, 32'h40, 6'd9);
        flush_valid = 1'b1; flush_wfid = 6'd9;
        tick();
        drive(1'b0, 32'h0, 6'd0);
        flush_valid = 1'b0;
        chk("t5_dead_occ",   64'(a_occ), 64'd1);
        chk("t5_dead_valid", 64'(a_out_valid), 64'd0);
        tick();
        chk("t5_drop_occ",   64'(a_occ), 64'd0);
        chk("t5_drop_valid", 64'(a_out_valid), 64'd0);
        drive(1'b1, 32'h44, 6'd1);
        flush_all = 1'b1;
        tick();
        drive(1'b0, 32'h0, 6'd0);
        flush_all = 1'b0;
        chk("t5_all_occ",   64'(a_occ), 64'd1);
        chk("t5_all_valid", 64'(a_out_valid), 64'd0);
        tick();
        chk("t5_all_drop_occ", 64'(a_occ), 64'd0);
        drive(1'b1, 32'h48, 6'd2);
        flush_valid = 1'b1; flush_wfid = 6'd9;
        tick();
        drive(1'b0, 32'h0, 6'd0);
        flush_valid = 1'b0;
        chk("t5_other_valid", 64'(a_out_valid), 64'd1);
        chk("t5_other_pc",    64'(a_pc), 64'h48);
        tick();

        // T6: random push/pop on DEPTH=4 against a reference queue
        rst_n = 1'b0; #1 rst_n = 1'b1;
        tick();
        for (int c = 0; c < 50; c++) begin
            mv  = ($urandom_range(0, 3) != 0);
            mr  = ($urandom_range(0, 1) != 0);
            rpc = $urandom;
            drive(mv, rpc, 6'($urandom_range(0, 63)));
            out_ready = mr;
            #1;
            chk("t6_occ",   64'(b_occ), 64'(q.size()));
            chk("t6_ready", 64'(b_in_ready), 64'(q.size() < 4));
            chk("t6_valid", 64'(b_out_valid), 64'(q.size() != 0));
            if (q.size() != 0) chk("t6_pc", 64'(b_pc), 64'(q[0]));
            do_push = mv && (q.size() < 4);
            do_pop  = mr && (q.size() != 0);
            tick();
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(rpc);
        end
        drive(1'b0, 32'h0, 6'd0);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
